// File: rtl/string_match_pkg.sv
// Shared types and default constants for the string-match engines.
// Packed strings keep character 0 in bits [7:0].
package string_match_pkg;

  typedef logic [7:0] char_t;

  typedef enum logic [3:0] {
    FB_IDLE    = 4'd0,
    FB_COMPARE = 4'd1,
    FB_FOUND   = 4'd2,
    FB_DONE    = 4'd3
  } fb_state_t;

  typedef enum logic [3:0] {
    KMP_IDLE    = 4'd0,
    KMP_PREFIX  = 4'd4,
    KMP_COMPARE = 4'd5,
    KMP_FOUND   = 4'd6,
    KMP_DONE    = 4'd7
  } kmp_state_t;

  localparam int DEFAULT_TEXT_LEN = 16;
  localparam int DEFAULT_PAT_LEN  = 4;

  // SV literals put the first character in the MSBs, so these read reversed:
  // text "ABABCABABABCABAB", pattern "ABAB".
  localparam logic [8*DEFAULT_TEXT_LEN-1:0] DEFAULT_TEXT    = "BABACBABABACBABA";
  localparam logic [8*DEFAULT_PAT_LEN-1:0]  DEFAULT_PATTERN = "BABA";

  function automatic char_t sat_inc(input char_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/string_match_kmp.sv
// Knuth-Morris-Pratt engine: builds the failure table one step per cycle,
// then scans the text from start_idx counting overlapping matches.
module kmp_matcher
  import string_match_pkg::*;
#(
  parameter int                      TEXT_LEN = DEFAULT_TEXT_LEN,
  parameter int                      PAT_LEN  = DEFAULT_PAT_LEN,
  parameter logic [8*TEXT_LEN-1:0]   TEXT     = DEFAULT_TEXT,
  parameter logic [8*PAT_LEN-1:0]    PATTERN  = DEFAULT_PATTERN
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic [7:0] start_idx,
  output logic [7:0] count,
  output logic [7:0] patron,
  output logic [7:0] texto,
  output logic [3:0] state_code
);

  localparam logic [8:0] TEXT_LEN_W = 9'(TEXT_LEN);
  localparam logic [4:0] PAT_LEN_Q  = 5'(PAT_LEN);
  localparam logic [3:0] PAT_LAST   = 4'(PAT_LEN - 1);

  char_t text_arr [256];
  char_t pat_arr  [16];

  for (genvar gi = 0; gi < 256; gi++) begin : g_text
    if (gi < TEXT_LEN) begin : g_used
      assign text_arr[gi] = TEXT[8*gi +: 8];
    end else begin : g_pad
      assign text_arr[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_pat
    if (gi < PAT_LEN) begin : g_used
      assign pat_arr[gi] = PATTERN[8*gi +: 8];
    end else begin : g_pad
      assign pat_arr[gi] = '0;
    end
  end

  kmp_state_t state_reg, state_next;
  logic [7:0] i_reg, i_next;
  logic [4:0] q_reg, q_next;
  logic [4:0] pq_reg, pq_next;
  logic [3:0] len_reg, len_next;
  char_t      count_reg, count_next;
  char_t      patron_reg, patron_next;
  char_t      texto_reg, texto_next;
  logic [3:0] fail_reg [16];
  logic [3:0] fail_next [16];
  logic [3:0] q_lo;

  assign q_lo = q_reg[3:0] - 4'd1;

  always_comb begin
    state_next  = state_reg;
    i_next      = i_reg;
    q_next      = q_reg;
    pq_next     = pq_reg;
    len_next    = len_reg;
    count_next  = count_reg;
    patron_next = '0;
    texto_next  = '0;
    fail_next   = fail_reg;
    case (state_reg)
      KMP_IDLE, KMP_DONE: begin
        if (start) begin
          count_next   = '0;
          i_next       = start_idx;
          q_next       = '0;
          pq_next      = 5'd1;
          len_next     = '0;
          fail_next[0] = '0;
          state_next   = KMP_PREFIX;
        end
      end
      KMP_PREFIX: begin
        if (pq_reg >= PAT_LEN_Q) begin
          q_next     = '0;
          state_next = KMP_COMPARE;
        end else if (pat_arr[pq_reg[3:0]] == pat_arr[len_reg]) begin
          fail_next[pq_reg[3:0]] = len_reg + 4'd1;
          len_next = len_reg + 4'd1;
          pq_next  = pq_reg + 5'd1;
        end else if (len_reg != 4'd0) begin
          len_next = fail_reg[len_reg - 4'd1];
        end else begin
          fail_next[pq_reg[3:0]] = '0;
          pq_next = pq_reg + 5'd1;
        end
      end
      KMP_COMPARE: begin
        if ({1'b0, i_reg} >= TEXT_LEN_W) begin
          state_next = KMP_DONE;
        end else begin
          texto_next  = text_arr[i_reg];
          patron_next = pat_arr[q_reg[3:0]];
          if (text_arr[i_reg] == pat_arr[q_reg[3:0]]) begin
            i_next = i_reg + 8'd1;
            q_next = q_reg + 5'd1;
            if (q_reg + 5'd1 == PAT_LEN_Q) state_next = KMP_FOUND;
          end else if (q_reg != 5'd0) begin
            q_next = {1'b0, fail_reg[q_lo]};
          end else begin
            i_next = i_reg + 8'd1;
          end
        end
      end
      KMP_FOUND: begin
        count_next = sat_inc(count_reg);
        q_next     = {1'b0, fail_reg[PAT_LAST]};
        state_next = KMP_COMPARE;
      end
      default: state_next = KMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg  <= KMP_IDLE;
      i_reg      <= '0;
      q_reg      <= '0;
      pq_reg     <= '0;
      len_reg    <= '0;
      count_reg  <= '0;
      patron_reg <= '0;
      texto_reg  <= '0;
      for (int k = 0; k < 16; k++) fail_reg[k] <= '0;
    end else begin
      state_reg  <= state_next;
      i_reg      <= i_next;
      q_reg      <= q_next;
      pq_reg     <= pq_next;
      len_reg    <= len_next;
      count_reg  <= count_next;
      patron_reg <= patron_next;
      texto_reg  <= texto_next;
      fail_reg   <= fail_next;
    end
  end

  assign count      = count_reg;
  assign patron     = patron_reg;
  assign texto      = texto_reg;
  assign state_code = state_reg;

endmodule

// File: rtl/string_match_top.sv
// Pattern search with a brute-force engine (inline) and a KMP engine;
// a start-button rising edge launches whichever engine sw_sel picks.
module string_match_top
  import string_match_pkg::*;
#(
  parameter int                      TEXT_LEN = DEFAULT_TEXT_LEN,
  parameter int                      PAT_LEN  = DEFAULT_PAT_LEN,
  parameter logic [8*TEXT_LEN-1:0]   TEXT     = DEFAULT_TEXT,
  parameter logic [8*PAT_LEN-1:0]    PATTERN  = DEFAULT_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inicio,
  input  logic       sw_sel,
  input  logic [7:0] sw_bit_inicial,
  output logic [7:0] display_FB,
  output logic [7:0] display_KMP,
  output logic [7:0] patron_FB,
  output logic [7:0] texto_FB,
  output logic [7:0] patron_KMP,
  output logic [7:0] texto_KMP,
  output logic [3:0] actual_state_FB,
  output logic [3:0] actual_state_KMP
);

  localparam logic [8:0] TEXT_LEN_W = 9'(TEXT_LEN);
  localparam logic [8:0] PAT_LEN_W  = 9'(PAT_LEN);
  localparam logic [3:0] PAT_LAST   = 4'(PAT_LEN - 1);

  char_t text_arr [256];
  char_t pat_arr  [16];

  for (genvar gi = 0; gi < 256; gi++) begin : g_text
    if (gi < TEXT_LEN) begin : g_used
      assign text_arr[gi] = TEXT[8*gi +: 8];
    end else begin : g_pad
      assign text_arr[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_pat
    if (gi < PAT_LEN) begin : g_used
      assign pat_arr[gi] = PATTERN[8*gi +: 8];
    end else begin : g_pad
      assign pat_arr[gi] = '0;
    end
  end

  // armed_reg blocks a start while the button has been high ever since reset.
  logic btn_prev_reg, armed_reg;
  logic start_edge, start_fb, start_kmp;

  assign start_edge = armed_reg & btn_inicio & ~btn_prev_reg;
  assign start_fb   = start_edge & ~sw_sel;
  assign start_kmp  = start_edge & sw_sel;

  fb_state_t  fb_state_reg, fb_state_next;
  logic [7:0] fb_i_reg, fb_i_next;
  logic [3:0] fb_j_reg, fb_j_next;
  char_t      fb_count_reg, fb_count_next;
  char_t      fb_patron_reg, fb_patron_next;
  char_t      fb_texto_reg, fb_texto_next;
  char_t      fb_t, fb_p;

  assign fb_t = text_arr[fb_i_reg + {4'd0, fb_j_reg}];
  assign fb_p = pat_arr[fb_j_reg];

  always_comb begin
    fb_state_next  = fb_state_reg;
    fb_i_next      = fb_i_reg;
    fb_j_next      = fb_j_reg;
    fb_count_next  = fb_count_reg;
    fb_patron_next = '0;
    fb_texto_next  = '0;
    case (fb_state_reg)
      FB_IDLE, FB_DONE: begin
        if (start_fb) begin
          fb_count_next = '0;
          fb_i_next     = sw_bit_inicial;
          fb_j_next     = '0;
          fb_state_next = FB_COMPARE;
        end
      end
      FB_COMPARE: begin
        if ({1'b0, fb_i_reg} + PAT_LEN_W > TEXT_LEN_W) begin
          fb_state_next = FB_DONE;
        end else begin
          fb_patron_next = fb_p;
          fb_texto_next  = fb_t;
          if (fb_t == fb_p && fb_j_reg == PAT_LAST) begin
            fb_state_next = FB_FOUND;
          end else if (fb_t == fb_p) begin
            fb_j_next = fb_j_reg + 4'd1;
          end else begin
            fb_i_next = fb_i_reg + 8'd1;
            fb_j_next = '0;
          end
        end
      end
      FB_FOUND: begin
        fb_count_next = sat_inc(fb_count_reg);
        fb_i_next     = fb_i_reg + 8'd1;
        fb_j_next     = '0;
        fb_state_next = FB_COMPARE;
      end
      default: fb_state_next = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_reg  <= 1'b0;
      armed_reg     <= 1'b0;
      fb_state_reg  <= FB_IDLE;
      fb_i_reg      <= '0;
      fb_j_reg      <= '0;
      fb_count_reg  <= '0;
      fb_patron_reg <= '0;
      fb_texto_reg  <= '0;
    end else begin
      btn_prev_reg  <= btn_inicio;
      if (btn_inicio == 1'b0) armed_reg <= 1'b1;
      fb_state_reg  <= fb_state_next;
      fb_i_reg      <= fb_i_next;
      fb_j_reg      <= fb_j_next;
      fb_count_reg  <= fb_count_next;
      fb_patron_reg <= fb_patron_next;
      fb_texto_reg  <= fb_texto_next;
    end
  end

  assign display_FB      = fb_count_reg;
  assign patron_FB       = fb_patron_reg;
  assign texto_FB        = fb_texto_reg;
  assign actual_state_FB = fb_state_reg;

  kmp_matcher #(
    .TEXT_LEN (TEXT_LEN),
    .PAT_LEN  (PAT_LEN),
    .TEXT     (TEXT),
    .PATTERN  (PATTERN)
  ) u_kmp (
    .clk        (clk),
    .srst       (rst),
    .start      (start_kmp),
    .start_idx  (sw_bit_inicial),
    .count      (display_KMP),
    .patron     (patron_KMP),
    .texto      (texto_KMP),
    .state_code (actual_state_KMP)
  );

endmodule

// File: tb/tb_string_match_top.sv
// Randomized and directed bench for string_match_top against a plain
// substring-counting reference model.
module tb_string_match_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inicio;
  logic       sw_sel;
  logic [7:0] sw_bit_inicial;
  logic [7:0] display_FB, display_KMP, patron_FB, texto_FB, patron_KMP, texto_KMP;
  logic [3:0] actual_state_FB, actual_state_KMP;

  int checks = 0;
  int errors = 0;
  int exp_fb = 0;
  int exp_kmp = 0;

  string txt = "ABABCABABABCABAB";
  string pat = "ABAB";

  always #5 clk = ~clk;

  string_match_top dut (
    .clk              (clk),
    .rst              (rst),
    .btn_inicio       (btn_inicio),
    .sw_sel           (sw_sel),
    .sw_bit_inicial   (sw_bit_inicial),
    .display_FB       (display_FB),
    .display_KMP      (display_KMP),
    .patron_FB        (patron_FB),
    .texto_FB         (texto_FB),
    .patron_KMP       (patron_KMP),
    .texto_KMP        (texto_KMP),
    .actual_state_FB  (actual_state_FB),
    .actual_state_KMP (actual_state_KMP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_count(input int start);
    int n = 0;
    for (int s = start; s + pat.len() <= txt.len(); s++) begin
      if (txt.substr(s, s + pat.len() - 1) == pat) n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Called at a negedge; returns at the following negedge with the button released.
  task automatic press(input logic sel, input logic [7:0] idx);
    sw_sel         = sel;
    sw_bit_inicial = idx;
    btn_inicio     = 1'b1;
    @(negedge clk);
    btn_inicio     = 1'b0;
  endtask

  task automatic wait_done(input logic sel, output bit seen_prefix, output bit seen_compare);
    logic [3:0] st;
    logic [3:0] done_code;
    done_code    = sel ? 4'd7 : 4'd3;
    seen_prefix  = 0;
    seen_compare = 0;
    st           = sel ? actual_state_KMP : actual_state_FB;
    for (int k = 0; k < 2000; k++) begin
      st = sel ? actual_state_KMP : actual_state_FB;
      if (st == 4'd4) seen_prefix = 1;
      if (st == 4'd5) seen_compare = 1;
      if (st == done_code) break;
      @(negedge clk);
    end
    check(sel ? "kmp_reach_done" : "fb_reach_done", st, done_code);
  endtask

  task automatic run(input logic sel, input logic [7:0] idx, input string tag);
    bit sp, sc;
    press(sel, idx);
    wait_done(sel, sp, sc);
    if (sel) exp_kmp = ref_count(idx);
    else     exp_fb  = ref_count(idx);
    check({tag, "_fb_count"}, display_FB, exp_fb);
    check({tag, "_kmp_count"}, display_KMP, exp_kmp);
    check({tag, "_operands_idle"}, sel ? {patron_KMP, texto_KMP} : {patron_FB, texto_FB}, 0);
    $display("run %s sel=%0d idx=%0d fb=%0d kmp=%0d", tag, sel, idx, display_FB, display_KMP);
  endtask

  initial begin
    bit sp, sc;
    logic       rsel;
    logic [7:0] ridx;

    rst = 1'b1;
    btn_inicio = 1'b0;
    sw_sel = 1'b0;
    sw_bit_inicial = 8'd0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_display_fb", display_FB, 0);
    check("rst_display_kmp", display_KMP, 0);
    check("rst_patron_fb", patron_FB, 0);
    check("rst_texto_fb", texto_FB, 0);
    check("rst_patron_kmp", patron_KMP, 0);
    check("rst_texto_kmp", texto_KMP, 0);
    check("rst_state_fb", actual_state_FB, 0);
    check("rst_state_kmp", actual_state_KMP, 0);

    // FB from index 0; first compare operands appear one cycle after the start.
    press(1'b0, 8'd0);
    @(negedge clk);
    check("fb_first_texto", texto_FB, txt[0]);
    check("fb_first_patron", patron_FB, pat[0]);
    wait_done(1'b0, sp, sc);
    exp_fb = ref_count(0);
    check("fb0_count", display_FB, exp_fb);
    check("fb0_kmp_untouched", display_KMP, 0);
    check("fb0_kmp_state", actual_state_KMP, 0);
    $display("run fb0 sel=0 idx=0 fb=%0d kmp=%0d", display_FB, display_KMP);

    // KMP from index 0, tracing PREFIX then COMPARE.
    press(1'b1, 8'd0);
    wait_done(1'b1, sp, sc);
    exp_kmp = ref_count(0);
    check("kmp0_saw_prefix", {31'd0, sp}, 1);
    check("kmp0_saw_compare", {31'd0, sc}, 1);
    check("kmp0_count", display_KMP, exp_kmp);
    check("kmp0_fb_untouched", display_FB, exp_fb);
    $display("run kmp0 sel=1 idx=0 fb=%0d kmp=%0d", display_FB, display_KMP);

    run(1'b0, 8'd6,   "fb6");
    run(1'b1, 8'd6,   "kmp6");
    run(1'b0, 8'd13,  "fb13");
    run(1'b1, 8'd13,  "kmp13");
    run(1'b0, 8'd200, "fb200");
    run(1'b1, 8'd200, "kmp200");

    for (int n = 0; n < 16; n++) begin
      rsel = 1'($urandom_range(0, 1));
      ridx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      run(rsel, ridx, "rand");
    end

    // Abort a KMP search with rst while the button is held high.
    run(1'b0, 8'd0, "fb_pre_rst");
    press(1'b1, 8'd0);
    for (int k = 0; k < 200; k++) begin
      if (actual_state_KMP == 4'd5) break;
      @(negedge clk);
    end
    check("kmp_reach_compare", actual_state_KMP, 5);
    rst = 1'b1;
    btn_inicio = 1'b1;
    @(negedge clk);
    check("abort_state_kmp", actual_state_KMP, 0);
    check("abort_display_kmp", display_KMP, 0);
    check("abort_display_fb", display_FB, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("held_btn_no_start_kmp", actual_state_KMP, 0);
    check("held_btn_no_start_fb", actual_state_FB, 0);
    btn_inicio = 1'b0;
    @(negedge clk);
    exp_fb = 0;
    run(1'b1, 8'd0, "kmp_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/string_match_top.md
Name: string_match_top

Overview:
- Top-level pattern-search block with two engines, brute force (FB) and Knuth-Morris-Pratt (KMP).
- Both engines count occurrences of a fixed pattern in a fixed text, starting at a switch-selected text index. Overlapping matches count.
- sw_sel picks which engine a start press launches.
- Each engine drives its own match-count display, the characters under comparison, and a 4-bit state code for board LEDs/debug.

Parameters:
- TEXT_LEN, 16, text length in characters (1..255).
- PAT_LEN, 4, pattern length (1..TEXT_LEN, 16 max).
- TEXT, "ABABCABABABCABAB", packed 8*TEXT_LEN bits; character 0 in bits [7:0].
- PATTERN, "ABAB", packed 8*PAT_LEN bits; character 0 in bits [7:0].

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_inicio  in  1  start button; a rising edge (registered, compared with previous sample) launches a search.
- sw_sel  in  1  engine select, sampled on the start edge: 0 = FB, 1 = KMP.
- sw_bit_inicial  in  8  starting text index.
- display_FB  out  8  FB match count.
- display_KMP  out  8  KMP match count.
- patron_FB  out  8  pattern character FB is comparing.
- texto_FB  out  8  text character FB is comparing.
- patron_KMP  out  8  pattern character KMP is comparing.
- texto_KMP  out  8  text character KMP is comparing.
- actual_state_FB  out  4  FB state code.
- actual_state_KMP  out  4  KMP state code.

Behaviour:
- Reset: all outputs 0, both FSMs in IDLE, edge-detect register 0. A start edge is only seen after btn_inicio was sampled 0 at least once after reset; X/unknown counts as no start.
- Start edge:
  - Ignored by an engine that is busy (not IDLE/DONE).
  - From IDLE or DONE, the selected engine clears its count and starts. The other engine is untouched.
- All outputs are registered. patron_*/texto_* show the operands of the current compare cycle and are 0 outside compare states.
- FB states (codes): IDLE=0, COMPARE=1, FOUND=2, DONE=3.
  - Init: i = sw_bit_inicial, j = 0.
  - COMPARE, one compare per cycle:
    - If i+PAT_LEN > TEXT_LEN → DONE.
    - text[i+j]==pat[j] with j==PAT_LEN-1 → FOUND.
    - Equal, otherwise → j++.
    - Unequal → i++, j=0.
  - FOUND: count++ (saturates at 255), i++, j=0, then COMPARE.
- KMP states (codes): IDLE=0, PREFIX=4, COMPARE=5, FOUND=6, DONE=7.
  - PREFIX builds the failure table fail[0..PAT_LEN-1], one standard step per cycle (len/q indices, fail[0]=0).
  - COMPARE init: i = sw_bit_inicial, q = 0.
    - If i >= TEXT_LEN → DONE.
    - text[i]==pat[q] → i++, q++. If the new q == PAT_LEN → FOUND.
    - Unequal, q>0 → q = fail[q-1] (i held).
    - Unequal, q==0 → i++.
  - FOUND: count++ (saturate), q = fail[PAT_LEN-1], back to COMPARE.
- DONE: display holds the final count and state holds its code until the next start edge or rst.
- sw_bit_inicial >= TEXT_LEN: that engine goes to DONE with count 0.
- rst mid-search aborts the search and returns everything to reset values on the next edge.
- FB and KMP must produce identical final counts for any start index.

Decomposition:
- Package string_match_pkg holds:
  - FB and KMP state enums, 4-bit, with the codes above;
  - char_t (8-bit);
  - default TEXT and PATTERN constants.
- One sub-module is natural: kmp_matcher, containing the PREFIX table builder and the search FSM.
- The FB engine and start edge-detect live inline in string_match_top.

Test Plan:
- rst=1 for 15 cycles, then rst=0 → all outputs 0, both states 0.
- sw_sel=0, sw_bit_inicial=0, pulse btn_inicio → actual_state_FB ends at 3, display_FB=4 (matches at 0,5,7,12). KMP outputs stay 0.
- sw_sel=1, sw_bit_inicial=0, pulse btn_inicio → actual_state_KMP passes through 4 then 5, ends at 7, display_KMP=4.
- sw_bit_inicial=6, run each engine → both displays 2.
- sw_bit_inicial=13 → FB count 0. sw_bit_inicial=200 → both engines DONE with count 0.
- Start KMP, assert rst during COMPARE → next cycle state 0, display 0. Then start again with btn held high → no restart until btn goes low then high.
